// File: rtl/triangle_seq_pkg.sv
// Shared types and the next-value rule for the 0..MAX..0 bouncing counter stream.
package triangle_seq_pkg;

    localparam int unsigned MAX_W = 16;

    typedef enum logic [1:0] {ACQ1, ACQ2, TRACK, LOCKED} state_t;

    typedef struct packed {
        logic [MAX_W-1:0] value;
        logic             next_dir;
        logic             peak;
        logic             valley;
    } pred_t;

    // The endpoint repeat is the sample that flips direction and raises the event flag.
    function automatic pred_t next_expected(input logic [MAX_W-1:0] p, input logic d,
                                            input int unsigned width);
        logic [MAX_W-1:0] maxv;
        pred_t            r;
        maxv       = {MAX_W{1'b1}} >> (MAX_W - width);
        r.value    = p;
        r.next_dir = d;
        r.peak     = 1'b0;
        r.valley   = 1'b0;
        if (d) begin
            if (p == maxv) begin
                r.next_dir = 1'b0;
                r.peak     = 1'b1;
            end else begin
                r.value = p + MAX_W'(1);
            end
        end else begin
            if (p == '0) begin
                r.next_dir = 1'b1;
                r.valley   = 1'b1;
            end else begin
                r.value = p - MAX_W'(1);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/triangle_seq_checker_predictor.sv
// Combinational check of one sample against the value predicted from prev/dir.
module triangle_seq_predictor
    import triangle_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] prev,
    input  logic             dir,
    input  logic [WIDTH-1:0] sample,
    output logic             match,
    output logic             next_dir,
    output logic             peak,
    output logic             valley
);

    logic [MAX_W-1:0] prev_ext;
    logic [MAX_W-1:0] sample_ext;
    pred_t            pred;

    always_comb begin
        prev_ext               = '0;
        prev_ext[WIDTH-1:0]    = prev;
        sample_ext             = '0;
        sample_ext[WIDTH-1:0]  = sample;
        pred                   = next_expected(prev_ext, dir, WIDTH);
        match                  = (pred.value == sample_ext);
        next_dir               = pred.next_dir;
        peak                   = pred.peak;
        valley                 = pred.valley;
    end

endmodule

// File: rtl/triangle_seq_checker.sv
// Receive-side monitor for the bouncing up/down counter: acquires, tracks, locks, flags errors.
module triangle_seq_checker
    import triangle_seq_pkg::*;
#(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned LOCK_LEN = 8,
    parameter int unsigned ERR_W    = 8,
    parameter int unsigned PER_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             locked,
    output logic             dir_up,
    output logic             peak_pulse,
    output logic             valley_pulse,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic [PER_W-1:0] period_count
);

    localparam int unsigned      RUN_W  = 8;
    localparam logic [RUN_W-1:0] LOCK_V = RUN_W'(LOCK_LEN);
    localparam logic [WIDTH-1:0] MAX_V  = '1;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   prev_q, prev_d;
    logic               dir_q, dir_d;
    logic [RUN_W-1:0]   run_q, run_d;
    logic               locked_q, locked_d;
    logic               peak_q, peak_d;
    logic               valley_q, valley_d;
    logic               err_q, err_d;
    logic [ERR_W-1:0]   err_count_q, err_count_d;
    logic [PER_W-1:0]   period_count_q, period_count_d;

    logic pr_match, pr_dir, pr_peak, pr_valley;
    logic step_up, step_down, pair_ok, pair_dir;

    triangle_seq_predictor #(.WIDTH(WIDTH)) u_pred (
        .prev     (prev_q),
        .dir      (dir_q),
        .sample   (in_data),
        .match    (pr_match),
        .next_dir (pr_dir),
        .peak     (pr_peak),
        .valley   (pr_valley)
    );

    // Guards stop MAX->0 and 0->MAX from passing as a +/-1 step through wraparound.
    always_comb begin
        step_up   = (prev_q != MAX_V) && (in_data == prev_q + WIDTH'(1));
        step_down = (prev_q != '0)    && (in_data == prev_q - WIDTH'(1));
        pair_ok   = step_up || step_down || (in_data == prev_q && (prev_q == MAX_V || prev_q == '0));
        pair_dir  = step_up || (in_data == prev_q && prev_q == '0);
    end

    always_comb begin
        state_d        = state_q;
        prev_d         = prev_q;
        dir_d          = dir_q;
        run_d          = run_q;
        locked_d       = locked_q;
        peak_d         = 1'b0;
        valley_d       = 1'b0;
        err_d          = 1'b0;
        err_count_d    = err_count_q;
        period_count_d = period_count_q;
        if (in_valid) begin
            prev_d = in_data;
            unique case (state_q)
                ACQ1: state_d = ACQ2;
                ACQ2: begin
                    if (pair_ok) begin
                        dir_d    = pair_dir;
                        run_d    = RUN_W'(1);
                        locked_d = (run_d == LOCK_V);
                        state_d  = locked_d ? LOCKED : TRACK;
                    end
                end
                TRACK, LOCKED: begin
                    if (pr_match) begin
                        dir_d    = pr_dir;
                        peak_d   = pr_peak;
                        valley_d = pr_valley;
                        if (state_q == TRACK) begin
                            run_d = run_q + RUN_W'(1);
                            if (run_d == LOCK_V) begin
                                state_d  = LOCKED;
                                locked_d = 1'b1;
                            end
                        end else if (pr_valley) begin
                            period_count_d = period_count_q + PER_W'(1);
                        end
                    end else begin
                        state_d  = ACQ2;
                        run_d    = '0;
                        locked_d = 1'b0;
                        if (state_q == LOCKED) begin
                            err_d = 1'b1;
                            if (err_count_q != '1) err_count_d = err_count_q + ERR_W'(1);
                        end
                    end
                end
                default: state_d = ACQ1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ACQ1;
            prev_q         <= '0;
            dir_q          <= 1'b0;
            run_q          <= '0;
            locked_q       <= 1'b0;
            peak_q         <= 1'b0;
            valley_q       <= 1'b0;
            err_q          <= 1'b0;
            err_count_q    <= '0;
            period_count_q <= '0;
        end else begin
            state_q        <= state_d;
            prev_q         <= prev_d;
            dir_q          <= dir_d;
            run_q          <= run_d;
            locked_q       <= locked_d;
            peak_q         <= peak_d;
            valley_q       <= valley_d;
            err_q          <= err_d;
            err_count_q    <= err_count_d;
            period_count_q <= period_count_d;
        end
    end

    assign locked       = locked_q;
    assign dir_up       = dir_q;
    assign peak_pulse   = peak_q;
    assign valley_pulse = valley_q;
    assign err_pulse    = err_q;
    assign err_count    = err_count_q;
    assign period_count = period_count_q;

endmodule

// File: tb/tb_triangle_seq_checker.sv
// Self-checking bench: phase-based triangle model checked every cycle plus literal pins.
module tb_triangle_seq_checker;

    localparam int M        = 15;
    localparam int N        = 2 * M + 2;
    localparam int LOCK_LEN = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [3:0]  in_data = '0;
    logic        locked, dir_up, peak_pulse, valley_pulse, err_pulse;
    logic [7:0]  err_count;
    logic [15:0] period_count;

    int vectors = 0;
    int miscompares = 0;

    triangle_seq_checker #(.WIDTH(4), .LOCK_LEN(LOCK_LEN), .ERR_W(8), .PER_W(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .locked       (locked),
        .dir_up       (dir_up),
        .peak_pulse   (peak_pulse),
        .valley_pulse (valley_pulse),
        .err_pulse    (err_pulse),
        .err_count    (err_count),
        .period_count (period_count)
    );

    always #5 clk = ~clk;

    // Model: position in the 2*(MAX+1)-sample period; phase 0 = second 0, phase M+1 = second MAX.
    bit m_have_first, m_tracking, m_locked, m_dir;
    int m_first, m_phase, m_run;
    bit e_peak, e_valley, e_err;
    int e_errc, e_per;

    function automatic int tri_val(input int k);
        return (k <= M) ? k : 2 * M + 1 - k;
    endfunction

    task automatic model_reset();
        m_have_first = 0; m_tracking = 0; m_locked = 0; m_dir = 0;
        m_first = 0; m_phase = 0; m_run = 0;
        e_peak = 0; e_valley = 0; e_err = 0; e_errc = 0; e_per = 0;
    endtask

    task automatic model_step(input bit v, input int s);
        int nk, k;
        e_peak = 0; e_valley = 0; e_err = 0;
        if (!v) return;
        if (m_tracking) begin
            nk = (m_phase + 1) % N;
            if (s == tri_val(nk)) begin
                m_phase  = nk;
                e_peak   = (nk == M + 1);
                e_valley = (nk == 0);
                if (e_valley && m_locked) e_per = (e_per + 1) % 65536;
                m_run++;
                if (m_run >= LOCK_LEN) m_locked = 1;
                m_dir = (nk <= M);
            end else begin
                if (m_locked) begin
                    e_err = 1;
                    if (e_errc < 255) e_errc++;
                end
                m_locked = 0; m_tracking = 0; m_run = 0;
                m_have_first = 1; m_first = s;
            end
        end else if (!m_have_first) begin
            m_have_first = 1; m_first = s;
        end else begin
            if (s == m_first + 1)                k = s;
            else if (s == m_first - 1)           k = 2 * M + 1 - s;
            else if (s == m_first && s == M)     k = M + 1;
            else if (s == m_first && s == 0)     k = 0;
            else                                 k = -1;
            if (k >= 0) begin
                m_tracking = 1; m_phase = k; m_run = 1;
                m_dir = (k <= M); m_locked = (LOCK_LEN <= 1);
            end else begin
                m_first = s;
            end
        end
    endtask

    // Compare process: update the model from what the DUT sampled, check just after the edge.
    initial begin
        bit r, v;
        int d;
        forever begin
            @(posedge clk);
            r = reset; v = in_valid; d = int'(in_data);
            if (r) model_reset();
            else   model_step(v, d);
            #1;
            vectors++;
            if (locked !== m_locked || dir_up !== m_dir || peak_pulse !== e_peak ||
                valley_pulse !== e_valley || err_pulse !== e_err ||
                err_count !== 8'(e_errc) || period_count !== 16'(e_per)) begin
                miscompares++;
                $display("FAIL cycle_check t=%0t got lk=%b dir=%b pk=%b vl=%b er=%b ec=%0d pc=%0d want lk=%b dir=%b pk=%b vl=%b er=%b ec=%0d pc=%0d",
                         $time, locked, dir_up, peak_pulse, valley_pulse, err_pulse, err_count, period_count,
                         m_locked, m_dir, e_peak, e_valley, e_err, e_errc, e_per);
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog time limit expired");
        miscompares++;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "timeout");
    end

    task automatic pin(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic send(input int v, input bit valid);
        @(negedge clk);
        reset = 1'b0; in_valid = valid; in_data = 4'(v);
        @(posedge clk); #2;
    endtask

    task automatic send_reset();
        @(negedge clk);
        reset = 1'b1; in_valid = 1'($urandom); in_data = 4'($urandom);
        @(posedge clk); #2;
    endtask

    int ph;

    task automatic stream(input int n, input bit gap);
        for (int i = 0; i < n; i++) begin
            ph = (ph + 1) % N;
            send(tri_val(ph), 1'b1);
            if (gap) send(int'($urandom_range(0, 15)), 1'b0);
        end
    endtask

    initial begin
        int r, nv;
        send_reset(); send_reset();
        pin("reset_locked", int'(locked), 0);
        pin("reset_dir", int'(dir_up), 0);
        pin("reset_errc", int'(err_count), 0);

        // Clean stream 0,0,1,2,...
        ph = 30;
        stream(8, 0);
        pin("lock_after_8", int'(locked), 0);
        stream(1, 0);
        pin("lock_after_9", int'(locked), 1);
        pin("model_lock_after_9", int'(m_locked), 1);
        stream(9, 0);
        pin("peak_second_15", int'(peak_pulse), 1);
        pin("model_peak", int'(e_peak), 1);
        pin("clean_errc", int'(err_count), 0);

        // Replace a rising 7 with 9
        stream(22, 0);
        ph = 7; send(9, 1'b1);
        pin("inject_err", int'(err_pulse), 1);
        pin("inject_errc", int'(err_count), 1);
        pin("inject_unlock", int'(locked), 0);
        pin("inject_no_peak", int'(peak_pulse), 0);
        pin("inject_no_valley", int'(valley_pulse), 0);
        stream(1, 0);
        pin("err_one_cycle", int'(err_pulse), 0);
        stream(8, 0);
        pin("not_yet_relocked", int'(locked), 0);
        stream(1, 0);
        pin("relocked", int'(locked), 1);

        // Missing dwell at MAX
        stream(30, 0);
        send(14, 1'b1);
        pin("no_dwell_err", int'(err_pulse), 1);

        // Mid-stream start 15,15,14,13
        send_reset();
        pin("mid_reset_errc", int'(err_count), 0);
        send(15, 1'b1); send(15, 1'b1);
        pin("mid_dir_down", int'(dir_up), 0);
        send(14, 1'b1);
        pin("mid_14_ok", int'(err_pulse), 0);
        send(13, 1'b1);
        pin("mid_13_ok", int'(err_pulse), 0);
        pin("mid_13_errc", int'(err_count), 0);
        ph = 18;
        stream(14, 0);
        pin("valley_second_0", int'(valley_pulse), 1);
        pin("period_one", int'(period_count), 1);
        send(0, 1'b1);
        pin("triple_zero_err", int'(err_pulse), 1);

        // Gapped clean stream
        send_reset();
        ph = 30;
        stream(8, 1);
        pin("gap_lock_after_8", int'(locked), 0);
        stream(9, 1);
        pin("gap_lock", int'(locked), 1);
        stream(1, 0);
        pin("gap_peak", int'(peak_pulse), 1);
        send(0, 1'b0);
        pin("gap_peak_idle", int'(peak_pulse), 0);

        // Random stream with gaps, corruption and resets
        send_reset();
        ph = int'($urandom_range(0, N - 1));
        for (int i = 0; i < 1500; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 15)      send(int'($urandom_range(0, 15)), 1'b0);
            else if (r < 19) send(int'($urandom_range(0, 15)), 1'b1);
            else if (r < 20) send_reset();
            else             stream(1, 0);
        end

        // Error counter saturation
        send_reset();
        ph = 30;
        for (int i = 0; i < 300; i++) begin
            stream(24, 0);
            nv = (tri_val((ph + 1) % N) + 5) % 16;
            send(nv, 1'b1);
        end
        pin("errc_saturated", int'(err_count), 255);
        pin("model_errc_saturated", e_errc, 255);

        // Reset mid-stream, then a bad sample must not flag
        stream(24, 0);
        send_reset();
        pin("midrst_locked", int'(locked), 0);
        pin("midrst_errc", int'(err_count), 0);
        pin("midrst_period", int'(period_count), 0);
        send((tri_val((ph + 1) % N) + 7) % 16, 1'b1);
        pin("midrst_no_err", int'(err_pulse), 0);
        stream(4, 0);

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
